// File: rtl/ws_array_pkg.sv
// rtl/ws_array_pkg.sv - shared state type and accumulate helper for the weight-stationary array
package ws_array_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_FULL  = 2'd1,
    ST_DRAIN = 2'd2
  } ws_state_e;

  // Adds two sign-extended partial sums; with saturate set the result is
  // clamped to the signed range of 'width' bits, otherwise the caller keeps
  // the low 'width' bits for two's-complement wrap. Operands must fit in
  // 'width' bits (width <= 62), so the 64-bit sum can never overflow.
  function automatic logic signed [63:0] sat_add(
    input logic signed [63:0] a,
    input logic signed [63:0] b,
    input int                 width,
    input logic               saturate
  );
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = a + b;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (saturate) begin
      if (s > hi) s = hi;
      else if (s < lo) s = lo;
    end
    return s;
  endfunction

endpackage

// File: rtl/ws_pe.sv
// rtl/ws_pe.sv - one weight-stationary processing element with shadow weight bank
module ws_pe
  import ws_array_pkg::*;
#(
  parameter int IFMAP_WIDTH  = 16,
  parameter int WEIGHT_WIDTH = 16,
  parameter int OFMAP_WIDTH  = 32,
  parameter int SATURATE     = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [IFMAP_WIDTH-1:0]  ifmap_in,
  input  logic [OFMAP_WIDTH-1:0]  psum_in,
  input  logic                    token_in,
  input  logic                    shadow_we,
  input  logic [WEIGHT_WIDTH-1:0] shadow_data,
  output logic [IFMAP_WIDTH-1:0]  ifmap_out,
  output logic [OFMAP_WIDTH-1:0]  psum_out,
  output logic                    token_out
);

  logic [WEIGHT_WIDTH-1:0]                    act_w;
  logic [WEIGHT_WIDTH-1:0]                    shd_w;
  logic signed [WEIGHT_WIDTH-1:0]             w_use;
  logic signed [IFMAP_WIDTH+WEIGHT_WIDTH-1:0] prod;
  logic signed [OFMAP_WIDTH-1:0]              prod_ow;
  logic signed [63:0]                         sum;
  logic                                       unused_sum_hi;

  // The vector travelling with the swap token is the first one to use the
  // new bank, so it reads the shadow register directly in that cycle.
  assign w_use   = token_in ? shd_w : act_w;
  assign prod    = $signed(ifmap_in) * w_use;
  assign prod_ow = OFMAP_WIDTH'(prod);
  assign sum     = sat_add(64'($signed(psum_in)), 64'(prod_ow), OFMAP_WIDTH, SATURATE != 0);
  assign unused_sum_hi = ^sum[63:OFMAP_WIDTH];

  // Weight banks, forward ifmap/token and accumulate the partial sum downward.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_w     <= '0;
      shd_w     <= '0;
      ifmap_out <= '0;
      psum_out  <= '0;
      token_out <= 1'b0;
    end else begin
      if (shadow_we) shd_w <= shadow_data;
      if (en) begin
        ifmap_out <= ifmap_in;
        token_out <= token_in;
        psum_out  <= sum[OFMAP_WIDTH-1:0];
        if (token_in) act_w <= shd_w;
      end
    end
  end

endmodule

// File: rtl/ws_systolic_array.sv
// rtl/ws_systolic_array.sv - HxW weight-stationary systolic array with skew, deskew and weight loader
module ws_systolic_array
  import ws_array_pkg::*;
#(
  parameter int IFMAP_WIDTH  = 16,
  parameter int WEIGHT_WIDTH = 16,
  parameter int OFMAP_WIDTH  = 32,
  parameter int ARRAY_HEIGHT = 4,
  parameter int ARRAY_WIDTH  = 4,
  parameter int SATURATE     = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 en,
  input  logic                                 in_valid,
  input  logic [ARRAY_HEIGHT*IFMAP_WIDTH-1:0]  ifmap_in,
  input  logic [ARRAY_WIDTH*OFMAP_WIDTH-1:0]   ofmap_in,
  output logic [ARRAY_WIDTH*OFMAP_WIDTH-1:0]   ofmap_out,
  output logic                                 ofmap_valid,
  input  logic                                 wload_valid,
  output logic                                 wload_ready,
  input  logic [ARRAY_WIDTH*WEIGHT_WIDTH-1:0]  wload_data,
  input  logic                                 swap,
  output logic                                 swap_err
);

  localparam int H   = ARRAY_HEIGHT;
  localparam int W   = ARRAY_WIDTH;
  localparam int IW  = IFMAP_WIDTH;
  localparam int WW  = WEIGHT_WIDTH;
  localparam int OW  = OFMAP_WIDTH;
  localparam int L   = H + W - 1;
  localparam int RPW = (H > 1) ? $clog2(H) : 1;
  localparam int CW  = $clog2(H + W);

  ws_state_e      state;
  logic [RPW-1:0] rptr;
  logic [CW-1:0]  drain_cnt;
  logic           load_fire;
  logic           swap_go;
  logic [L-1:0]   vld_q;

  logic [IW-1:0] ifm [H][W+1];
  logic          tok [H][W+1];
  logic [OW-1:0] ps  [H+1][W];

  assign wload_ready = (state == ST_LOAD);
  assign load_fire   = en & wload_valid & wload_ready;
  assign swap_go     = en & swap & (state == ST_FULL);

  // Loader FSM: fill shadow rows, accept one swap, then wait for the token to leave the array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_LOAD;
      rptr      <= '0;
      drain_cnt <= '0;
      swap_err  <= 1'b0;
    end else begin
      swap_err <= en & swap & (state != ST_FULL);
      if (en) begin
        case (state)
          ST_LOAD: begin
            if (wload_valid) begin
              if (rptr == RPW'(H - 1)) begin
                state <= ST_FULL;
                rptr  <= '0;
              end else begin
                rptr <= rptr + 1'b1;
              end
            end
          end
          ST_FULL: begin
            if (swap) begin
              state     <= ST_DRAIN;
              drain_cnt <= CW'(H + W - 2);
            end
          end
          ST_DRAIN: begin
            if (drain_cnt == '0) state <= ST_LOAD;
            else drain_cnt <= drain_cnt - 1'b1;
          end
          default: state <= ST_LOAD;
        endcase
      end
    end
  end

  // Valid flag rides a pipeline as long as the array itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
    end else if (en) begin
      vld_q[0] <= in_valid;
      for (int i = 1; i < L; i++) vld_q[i] <= vld_q[i-1];
    end
  end
  assign ofmap_valid = vld_q[L-1];

  for (genvar gy = 0; gy < H; gy++) begin : g_row
    logic unused_tail;
    assign unused_tail = ^{ifm[gy][W], tok[gy][W]};

    if (gy == 0) begin : g_d0
      assign ifm[0][0] = ifmap_in[0 +: IW];
      assign tok[0][0] = swap_go;
    end else begin : g_dn
      logic [IW-1:0] d_q [gy];
      logic          t_q [gy];
      // Row skew: row gy and its swap token are delayed gy cycles together.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < gy; i++) begin
            d_q[i] <= '0;
            t_q[i] <= 1'b0;
          end
        end else if (en) begin
          d_q[0] <= ifmap_in[gy*IW +: IW];
          t_q[0] <= swap_go;
          for (int i = 1; i < gy; i++) begin
            d_q[i] <= d_q[i-1];
            t_q[i] <= t_q[i-1];
          end
        end
      end
      assign ifm[gy][0] = d_q[gy-1];
      assign tok[gy][0] = t_q[gy-1];
    end

    for (genvar gx = 0; gx < W; gx++) begin : g_col
      ws_pe #(
        .IFMAP_WIDTH (IW),
        .WEIGHT_WIDTH(WW),
        .OFMAP_WIDTH (OW),
        .SATURATE    (SATURATE)
      ) u_pe (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .ifmap_in   (ifm[gy][gx]),
        .psum_in    (ps[gy][gx]),
        .token_in   (tok[gy][gx]),
        .shadow_we  (load_fire && (rptr == RPW'(gy))),
        .shadow_data(wload_data[gx*WW +: WW]),
        .ifmap_out  (ifm[gy][gx+1]),
        .psum_out   (ps[gy+1][gx]),
        .token_out  (tok[gy][gx+1])
      );
    end
  end

  for (genvar gx = 0; gx < W; gx++) begin : g_colio
    if (gx == 0) begin : g_s0
      assign ps[0][0] = ofmap_in[0 +: OW];
    end else begin : g_sn
      logic [OW-1:0] s_q [gx];
      // Seed skew: column gx seed delayed gx cycles to meet its skewed ifmap.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < gx; i++) s_q[i] <= '0;
        end else if (en) begin
          s_q[0] <= ofmap_in[gx*OW +: OW];
          for (int i = 1; i < gx; i++) s_q[i] <= s_q[i-1];
        end
      end
      assign ps[0][gx] = s_q[gx-1];
    end

    if (gx == W - 1) begin : g_o0
      assign ofmap_out[gx*OW +: OW] = ps[H][gx];
    end else begin : g_on
      logic [OW-1:0] o_q [W-1-gx];
      // Deskew: column gx result delayed W-1-gx cycles so a vector leaves aligned.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < W - 1 - gx; i++) o_q[i] <= '0;
        end else if (en) begin
          o_q[0] <= ps[H][gx];
          for (int i = 1; i < W - 1 - gx; i++) o_q[i] <= o_q[i-1];
        end
      end
      assign ofmap_out[gx*OW +: OW] = o_q[W-2-gx];
    end
  end

endmodule

// File: tb/tb_ws_systolic_array.sv
// tb/tb_ws_systolic_array.sv - scoreboard bench for ws_systolic_array (wrap and saturate builds)
module tb_ws_systolic_array;
  import ws_array_pkg::*;

  typedef struct {
    logic [127:0] d;
    logic [127:0] ds;
    int           due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b1;
  logic         in_valid = 1'b0;
  logic         swap = 1'b0;
  logic         wload_valid = 1'b0;
  logic [63:0]  ifmap_in = '0;
  logic [63:0]  wload_data = '0;
  logic [127:0] ofmap_in = '0;
  logic [127:0] ofmap_out, ofmap_out_s;
  logic         ofmap_valid, ofmap_valid_s;
  logic         wload_ready, wload_ready_s;
  logic         swap_err, swap_err_s;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t q[$];
  exp_t me;

  ws_systolic_array #(.SATURATE(0)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid),
    .ifmap_in(ifmap_in), .ofmap_in(ofmap_in), .ofmap_out(ofmap_out),
    .ofmap_valid(ofmap_valid), .wload_valid(wload_valid), .wload_ready(wload_ready),
    .wload_data(wload_data), .swap(swap), .swap_err(swap_err)
  );

  ws_systolic_array #(.SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid),
    .ifmap_in(ifmap_in), .ofmap_in(ofmap_in), .ofmap_out(ofmap_out_s),
    .ofmap_valid(ofmap_valid_s), .wload_valid(wload_valid), .wload_ready(wload_ready_s),
    .wload_data(wload_data), .swap(swap), .swap_err(swap_err_s)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] v16(input int a, input int b, input int c, input int d);
    return {d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  function automatic logic [127:0] v32(input int a, input int b, input int c, input int d);
    return {d, c, b, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_rows(input int n, input logic [63:0] row);
    for (int i = 0; i < n; i++) begin
      wload_valid = 1'b1;
      wload_data  = row;
      tick();
    end
    wload_valid = 1'b0;
  endtask

  task automatic wait_load();
    int n = 0;
    while (!wload_ready && n < 50) begin
      tick();
      n++;
    end
    check("wait_load_ready", 128'(wload_ready), 128'(1));
  endtask

  task automatic wait_empty();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check("scoreboard_drained", 128'(q.size()), 128'(0));
  endtask

  task automatic send(input logic [63:0] ifm, input logic [127:0] seed, input logic sw,
                      input logic [127:0] exp_w, input logic [127:0] exp_s, input int extra);
    exp_t e;
    ifmap_in = ifm;
    ofmap_in = seed;
    swap     = sw;
    in_valid = 1'b1;
    e.d   = exp_w;
    e.ds  = exp_s;
    e.due = cyc + 7 + extra;
    q.push_back(e);
    tick();
    in_valid = 1'b0;
    swap     = 1'b0;
  endtask

  // Monitor: a result is taken on each advancing cycle that shows ofmap_valid.
  always @(negedge clk) begin
    if (!rst && en && ofmap_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%h required=no output", ofmap_out);
      end else begin
        me = q.pop_front();
        check("ofmap_out", ofmap_out, me.d);
        check("ofmap_out_sat", ofmap_out_s, me.ds);
        check("ofmap_valid_sat", 128'(ofmap_valid_s), 128'(1));
        check("latency_cycle", 128'(cyc), 128'(me.due));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick(); tick();
    rst = 1'b0;
    check("rst_ofmap_valid", 128'(ofmap_valid), 128'(0));
    check("rst_swap_err", 128'(swap_err), 128'(0));
    check("rst_wload_ready", 128'(wload_ready), 128'(1));
    check("rst_ofmap_out", ofmap_out, 128'(0));
    check("rst_state", 128'(dut.state), 128'(ST_LOAD));
    check("rst_rptr", 128'(dut.rptr), 128'(0));

    // Identity weights: result column x is seed + ifmap[x].
    for (int y = 0; y < 4; y++) load_rows(1, 64'h1 << (16 * y));
    check("full_after_4_rows", 128'(dut.state), 128'(ST_FULL));
    check("full_not_ready", 128'(wload_ready), 128'(0));
    send(v16(1, 1, 1, 1), v32(7, 7, 7, 7), 1'b0, v32(7, 7, 7, 7), v32(7, 7, 7, 7), 0);
    send(v16(1, 2, 3, 4), v32(10, 10, 10, 10), 1'b1, v32(11, 12, 13, 14), v32(11, 12, 13, 14), 0);
    check("swap_ok_no_err", 128'(swap_err), 128'(0));
    send(v16(5, -6, 7, 0), v32(0, 1, 2, 3), 1'b0, v32(5, -5, 9, 3), v32(5, -5, 9, 3), 0);

    // Bank boundary: A on old weights (1), B with swap on new weights (2).
    wait_load();
    load_rows(4, v16(1, 1, 1, 1));
    swap = 1'b1;
    tick();
    swap = 1'b0;
    wait_load();
    load_rows(4, v16(2, 2, 2, 2));
    send(v16(1, 1, 1, 1), v32(0, 0, 0, 0), 1'b0, v32(4, 4, 4, 4), v32(4, 4, 4, 4), 0);
    send(v16(1, 1, 1, 1), v32(0, 0, 0, 0), 1'b1, v32(8, 8, 8, 8), v32(8, 8, 8, 8), 0);

    // Swap during LOAD is rejected; loading resumes from row 2.
    wait_load();
    load_rows(2, v16(3, 3, 3, 3));
    send(v16(1, 1, 1, 1), v32(0, 0, 0, 0), 1'b1, v32(8, 8, 8, 8), v32(8, 8, 8, 8), 0);
    check("swap_err_pulse", 128'(swap_err), 128'(1));
    tick();
    check("swap_err_one_cycle", 128'(swap_err), 128'(0));
    check("rptr_after_reject", 128'(dut.rptr), 128'(2));
    check("state_after_reject", 128'(dut.state), 128'(ST_LOAD));
    load_rows(2, v16(3, 3, 3, 3));
    check("full_after_resume", 128'(wload_ready), 128'(0));
    send(v16(1, 2, 3, 4), v32(0, 0, 0, 0), 1'b1, v32(30, 30, 30, 30), v32(30, 30, 30, 30), 0);
    // Load attempts while draining must not touch the shadow bank in use.
    wload_valid = 1'b1;
    wload_data  = v16(9, 9, 9, 9);
    tick(); tick(); tick(); tick();
    wload_valid = 1'b0;
    check("drain_rptr_hold", 128'(dut.rptr), 128'(0));

    // en low three cycles mid-stream shifts every result by three.
    wait_load();
    send(v16(1, 0, 0, 0), v32(0, 0, 0, 0), 1'b0, v32(3, 3, 3, 3), v32(3, 3, 3, 3), 3);
    send(v16(0, 1, 0, 0), v32(1, 2, 3, 4), 1'b0, v32(4, 5, 6, 7), v32(4, 5, 6, 7), 3);
    send(v16(1, 1, 1, 1), v32(0, 0, 0, 0), 1'b0, v32(12, 12, 12, 12), v32(12, 12, 12, 12), 3);
    send(v16(2, -1, 0, 0), v32(100, 100, 100, 100), 1'b0, v32(103, 103, 103, 103), v32(103, 103, 103, 103), 3);
    en       = 1'b0;
    swap     = 1'b1;
    in_valid = 1'b1;
    ifmap_in = v16(77, 77, 77, 77);
    tick();
    check("stall_no_swap_err", 128'(swap_err), 128'(0));
    swap = 1'b0;
    tick(); tick();
    in_valid = 1'b0;
    en       = 1'b1;
    check("stall_state_hold", 128'(dut.state), 128'(ST_LOAD));

    // Overflow: wrap vs saturate builds.
    wait_load();
    load_rows(4, v16(32767, 32767, 32767, 32767));
    send(v16(32767, 32767, 32767, 32767), v32(0, 0, 0, 0), 1'b1,
         {4{32'hFFFC0004}}, {4{32'h7FFFFFFF}}, 0);
    send(v16(-32768, -32768, -32768, -32768), v32(0, 0, 0, 0), 1'b0,
         {4{32'h00020000}}, {4{32'h80000000}}, 0);

    // Reset mid-load with a vector in flight.
    wait_empty();
    wait_load();
    load_rows(2, v16(5, 5, 5, 5));
    in_valid = 1'b1;
    ifmap_in = v16(1, 1, 1, 1);
    ofmap_in = v32(1, 1, 1, 1);
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst2_wload_ready", 128'(wload_ready), 128'(1));
    check("rst2_rptr", 128'(dut.rptr), 128'(0));
    check("rst2_state", 128'(dut.state), 128'(ST_LOAD));
    check("rst2_ofmap_valid", 128'(ofmap_valid), 128'(0));
    check("rst2_ofmap_out", ofmap_out, 128'(0));
    load_rows(4, v16(1, 1, 1, 1));
    check("rst2_full", 128'(dut.state), 128'(ST_FULL));
    send(v16(1, 1, 1, 1), v32(5, 6, 7, 8), 1'b0, v32(5, 6, 7, 8), v32(5, 6, 7, 8), 0);
    send(v16(1, 2, 3, 4), v32(0, 1, 2, 3), 1'b1, v32(10, 11, 12, 13), v32(10, 11, 12, 13), 0);
    wait_empty();
    tick(); tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ws_systolic_array.md
WS_SYSTOLIC_ARRAY -- requirements
Module: ws_systolic_array

Interface
REQ-001 Parameter IFMAP_WIDTH, default 16, signed ifmap element width.
REQ-002 Parameter WEIGHT_WIDTH, default 16, signed weight width.
REQ-003 Parameter OFMAP_WIDTH, default 32, signed partial-sum width.
REQ-004 Parameter ARRAY_HEIGHT, default 4, PE rows (H); ARRAY_WIDTH, default 4, PE columns (W).
REQ-005 Parameter SATURATE, default 0; 1 = clamp accumulations, 0 = two's-complement wrap.
REQ-006 clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 en  in  1  global advance; when low, all state including skew/deskew holds.
REQ-009 in_valid  in  1  ifmap_in/ofmap_in hold a vector this cycle.
REQ-010 ifmap_in  in  H x IFMAP_WIDTH  unskewed input vector; row y feeds PE row y.
REQ-011 ofmap_in  in  W x OFMAP_WIDTH  unskewed partial-sum seed per column.
REQ-012 ofmap_out  out  W x OFMAP_WIDTH  deskewed results, aligned per vector.
REQ-013 ofmap_valid  out  1  ofmap_out holds a result.
REQ-014 wload_valid  in  1; wload_ready  out  1; wload_data  in  W x WEIGHT_WIDTH: one shadow-weight row per handshake.
REQ-015 swap  in  1  request shadow->active weight switch, aligned with the same-cycle vector.
REQ-016 swap_err  out  1  one-cycle pulse: swap rejected.

Function
REQ-017 Result: ofmap_out[x] = ofmap_in[x] + sum over y of ifmap_in[y]*W_active[y][x], products sign-extended to OFMAP_WIDTH.
REQ-018 Internal input skew: ifmap row y delayed y en-cycles; ofmap_in column x delayed x; output column x delayed W-1-x.
REQ-019 Latency L = H+W-1 en-cycles from in_valid to ofmap_valid; throughput one vector per en-cycle.
REQ-020 in_valid pipelined with the data; ofmap_valid is its L-delayed copy; invalid slots still compute but are flagged 0.
REQ-021 Each PE holds active and shadow weight registers; ifmap moves right, partial sums move down, one register stage per PE each.
REQ-022 SATURATE=1: each PE add done at OFMAP_WIDTH+1 bits, clamped to [-2^(OW-1), 2^(OW-1)-1]; SATURATE=0: truncated wrap.
REQ-023 Load FSM states LOAD, FULL, DRAIN; reset state LOAD.
REQ-024 LOAD: wload_ready=1; handshake writes wload_data to shadow row rptr, rptr++; handshake with rptr=H-1 -> FULL, rptr=0.
REQ-025 FULL: wload_ready=0; swap&en -> DRAIN, counter loaded with H+W-2.
REQ-026 Swap token enters row y with y-delay, travels right with ifmap; PE(y,x) copies shadow->active in the cycle the token reaches it.
REQ-027 Vectors presented before the swap cycle use old weights; the swap-cycle vector and later use new weights; no vector mixes banks.
REQ-028 DRAIN: wload_ready=0; counter decrements per en-cycle; at 0 -> LOAD next cycle.
REQ-029 swap&en in LOAD or DRAIN: ignored, no token, swap_err=1 next cycle.
REQ-030 wload_valid while wload_ready=0: ignored, no shadow write.
REQ-031 en=0: FSM, counters, tokens frozen; handshakes not accepted; swap_err not raised.

Reset
REQ-032 rst: all active/shadow weights, skew, pipeline, tokens and ofmap_out to 0; ofmap_valid=0, swap_err=0, rptr=0, state LOAD, wload_ready=1 from reset release.
REQ-033 rst mid-load or mid-drain discards partial loads and in-flight tokens; no post-reset output derives from pre-reset data.

Structure
REQ-034 Package ws_array_pkg holds the FSM state enum and saturating-add helper function.
REQ-035 One sub-module ws_pe: one PE with active/shadow weights, ifmap/psum/token registers, SATURATE parameter.
REQ-036 Skew/deskew are generated delay lines inside ws_systolic_array; no other hierarchy.

Verification (defaults H=W=4)
REQ-037 Load identity rows, swap, ifmap_in=[1,2,3,4], ofmap_in=[10,10,10,10] -> ofmap_out=[11,12,13,14], ofmap_valid 7 cycles after the input.
REQ-038 Active all 1, shadow all 2; vector A (ifmap all 1, seed 0) one cycle before vector B presented with swap -> A out [4,4,4,4], B out [8,8,8,8], consecutive cycles.
REQ-039 swap in LOAD after 2 rows -> swap_err pulse, results unchanged, loading continues to FULL after 2 more rows.
REQ-040 en low 3 cycles mid-stream -> each result delayed exactly 3 cycles, values identical to en-high run.
REQ-041 All weights and ifmap 32767, seed 0: SATURATE=1 -> 0x7FFFFFFF every column; SATURATE=0 -> 0xFFFC0004.
REQ-042 rst after 2 loaded rows -> wload_ready=1, rptr=0, state LOAD, ofmap_valid=0; 4 fresh rows reach FULL.
